fetch_stage: RTL and testbench

Instruction-fetch (IF) stage of the venus pipeline. It is the receiving end of the execute stage's branch interface: it consumes the taken-branch strobe and target address and redirects the program counter. It drives a synchronous instruction memory with fixed 1-cycle read latency. It buffers returned words in a 2-entry queue and presents them, with their fetch address, to ID under a valid/stall handshake.

---
 rtl/fetch_stage_if.sv | 29 ++
 rtl/fetch_stage.sv | 87 ++++++++
 tb/tb_fetch_stage.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage connection bundle: branch/halt from execute, instruction memory
// port and the valid/stall handshake to decode.
interface fetch_stage_if #(
    parameter int ADDR_W = 16,
    parameter int INST_W = 32
);
    logic              branch_i;
    logic [ADDR_W-1:0] baddr_i;
    logic              halt_i;
    logic              imem_req_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [INST_W-1:0] imem_data_i;
    logic              v_o;
    logic [INST_W-1:0] inst_o;
    logic [ADDR_W-1:0] addr_o;
    logic              stall_i;

    // Environment side: execute, instruction memory and decode.
    modport master (
        output branch_i, baddr_i, halt_i, imem_data_i, stall_i,
        input  imem_req_o, imem_addr_o, v_o, inst_o, addr_o
    );

    // Fetch stage side.
    modport slave (
        input  branch_i, baddr_i, halt_i, imem_data_i, stall_i,
        output imem_req_o, imem_addr_o, v_o, inst_o, addr_o
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC sequencing with branch redirect, 1-cycle
// synchronous imem, 2-entry return queue feeding decode.
module fetch_stage #(
    parameter int              ADDR_W   = 16,
    parameter int              INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.slave  bus
);
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_req_addr;
    logic              r_inflight;
    logic              r_halted;
    logic [1:0]        r_count;
    logic              r_head;
    logic [ADDR_W-1:0] r_q_addr [2];
    logic [INST_W-1:0] r_q_inst [2];

    logic              w_pop;
    logic              w_push;
    logic              w_can_issue;
    logic              w_seq_req;
    logic              w_req;
    logic [2:0]        w_occ;
    logic              w_wr_idx;

    assign w_pop       = (r_count != 2'd0) & ~bus.stall_i & ~bus.branch_i;
    assign w_push      = r_inflight & ~bus.branch_i;
    assign w_can_issue = ~r_halted & ~bus.halt_i;
    // Entries held or owed after this cycle; a new request needs a free slot.
    assign w_occ       = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_seq_req   = w_can_issue & (w_occ < 3'd2);
    assign w_req       = bus.branch_i ? w_can_issue : w_seq_req;
    // Tail slot is head+count mod 2; a push never happens with count=2.
    assign w_wr_idx    = r_head ^ r_count[0];

    assign bus.imem_req_o  = w_req & rst;
    assign bus.imem_addr_o = bus.branch_i ? bus.baddr_i : r_pc;
    assign bus.v_o         = (r_count != 2'd0);
    assign bus.inst_o      = r_q_inst[r_head];
    assign bus.addr_o      = r_q_addr[r_head];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc       <= RESET_PC;
            r_req_addr <= '0;
            r_inflight <= 1'b0;
            r_halted   <= 1'b0;
            r_count    <= '0;
            r_head     <= 1'b0;
        end else begin
            if (bus.halt_i) begin
                r_halted <= 1'b1;
            end
            if (bus.branch_i) begin
                r_count    <= '0;
                r_head     <= 1'b0;
                r_inflight <= w_can_issue;
                if (w_can_issue) begin
                    r_pc       <= bus.baddr_i + ADDR_W'(1);
                    r_req_addr <= bus.baddr_i;
                end else begin
                    r_pc <= bus.baddr_i;
                end
            end else begin
                r_count    <= r_count + {1'b0, w_push} - {1'b0, w_pop};
                r_inflight <= w_seq_req;
                if (w_pop) begin
                    r_head <= ~r_head;
                end
                if (w_seq_req) begin
                    r_pc       <= r_pc + ADDR_W'(1);
                    r_req_addr <= r_pc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_addr[w_wr_idx] <= r_req_addr;
            r_q_inst[w_wr_idx] <= bus.imem_data_i;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed latency/stall/branch/wrap/halt scenarios plus
// a randomized stall/branch run, delivered stream checked against a path model.
module tb_fetch_stage;
    localparam int             AW  = 16;
    localparam int             IW  = 32;
    localparam logic [AW-1:0]  RPC = '0;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [IW-1:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fetch_stage_if #(.ADDR_W(AW), .INST_W(IW)) bus ();

    fetch_stage #(.ADDR_W(AW), .INST_W(IW), .RESET_PC(RPC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t          exp_q[$];
    logic [AW-1:0] q_tail;
    int            n_cmp   = 0;
    int            n_err   = 0;
    int            n_deliv = 0;
    logic          prev_hold = 1'b0;
    logic [AW-1:0] prev_a;
    logic [IW-1:0] prev_d;
    exp_t          e_mon;

    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        return 32'hA000_0000 + IW'(a);
    endfunction

    function void chk(input string nm, input logic [IW-1:0] act, input logic [IW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %h required %h", nm, act, req);
        end
    endfunction

    // Expected delivery stream: sequential words from the last redirect point.
    function void topup();
        exp_t e;
        while (exp_q.size() < 8) begin
            e.a = q_tail;
            e.d = mem_word(q_tail);
            exp_q.push_back(e);
            q_tail = q_tail + AW'(1);
        end
    endfunction

    function void redirect(input logic [AW-1:0] a);
        exp_q.delete();
        q_tail = a;
        topup();
    endfunction

    // Synchronous instruction memory; garbage when not requested.
    always @(posedge clk) begin
        if (bus.imem_req_o) bus.imem_data_i <= mem_word(bus.imem_addr_o);
        else                bus.imem_data_i <= $urandom;
    end

    always @(negedge clk) begin
        if (!rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_v", 32'(bus.v_o), 32'd1);
                chk("hold_addr", 32'(bus.addr_o), 32'(prev_a));
                chk("hold_inst", bus.inst_o, prev_d);
            end
            if (bus.v_o && !bus.stall_i && !bus.branch_i) begin
                n_deliv++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL deliver: actual addr %h, required none", bus.addr_o);
                end else begin
                    e_mon = exp_q.pop_front();
                    chk("deliver_addr", 32'(bus.addr_o), 32'(e_mon.a));
                    chk("deliver_inst", bus.inst_o, e_mon.d);
                end
            end
            prev_hold = bus.v_o && bus.stall_i && !bus.branch_i;
            prev_a    = bus.addr_o;
            prev_d    = bus.inst_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        topup();
    endtask

    int d0;

    initial begin
        bus.branch_i = 1'b0;
        bus.baddr_i  = '0;
        bus.halt_i   = 1'b0;
        bus.stall_i  = 1'b0;
        redirect(RPC);
        repeat (3) tick();
        @(negedge clk);
        chk("rst_v", 32'(bus.v_o), 32'd0);
        chk("rst_req", 32'(bus.imem_req_o), 32'd0);
        tick();

        // Reset release: one request per cycle, first word 2 cycles later.
        rst = 1'b1;
        redirect(RPC);
        for (int unsigned k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t1_req", 32'(bus.imem_req_o), 32'd1);
            chk("t1_iaddr", 32'(bus.imem_addr_o), k);
            chk("t1_v", 32'(bus.v_o), 32'(k >= 2));
            if (k >= 2) begin
                chk("t1_addr", 32'(bus.addr_o), k - 2);
                chk("t1_inst", bus.inst_o, 32'hA000_0000 + k - 2);
            end
            tick();
        end

        // Stall with head at address 4.
        bus.stall_i = 1'b1;
        for (int unsigned j = 0; j < 5; j++) begin
            @(negedge clk);
            chk("t2_v", 32'(bus.v_o), 32'd1);
            chk("t2_addr", 32'(bus.addr_o), 32'd4);
            chk("t2_req", 32'(bus.imem_req_o), 32'd0);
            tick();
        end
        bus.stall_i = 1'b0;
        for (int unsigned j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("t2_rel_v", 32'(bus.v_o), 32'd1);
            chk("t2_rel_addr", 32'(bus.addr_o), 32'd4 + j);
            if (j == 0) begin
                chk("t2_resume_req", 32'(bus.imem_req_o), 32'd1);
                chk("t2_resume_iaddr", 32'(bus.imem_addr_o), 32'd6);
            end
            tick();
        end

        // Branch with a full queue.
        bus.stall_i = 1'b1;
        repeat (3) tick();
        bus.stall_i  = 1'b0;
        bus.branch_i = 1'b1;
        bus.baddr_i  = 16'h0100;
        redirect(16'h0100);
        @(negedge clk);
        chk("t3_req", 32'(bus.imem_req_o), 32'd1);
        chk("t3_iaddr", 32'(bus.imem_addr_o), 32'h0100);
        tick();
        bus.branch_i = 1'b0;
        @(negedge clk);
        chk("t3_v_gap", 32'(bus.v_o), 32'd0);
        tick();
        @(negedge clk);
        chk("t3_v", 32'(bus.v_o), 32'd1);
        chk("t3_addr0", 32'(bus.addr_o), 32'h0100);
        tick();
        @(negedge clk);
        chk("t3_addr1", 32'(bus.addr_o), 32'h0101);
        tick();

        // Branch with stall and a response arriving together.
        repeat (2) tick();
        bus.branch_i = 1'b1;
        bus.stall_i  = 1'b1;
        bus.baddr_i  = 16'h0200;
        redirect(16'h0200);
        @(negedge clk);
        chk("t4_iaddr", 32'(bus.imem_addr_o), 32'h0200);
        tick();
        bus.branch_i = 1'b0;
        bus.stall_i  = 1'b0;
        @(negedge clk);
        chk("t4_v_gap", 32'(bus.v_o), 32'd0);
        tick();
        @(negedge clk);
        chk("t4_addr", 32'(bus.addr_o), 32'h0200);
        chk("t4_inst", bus.inst_o, 32'hA000_0200);
        tick();

        // Address wrap.
        bus.branch_i = 1'b1;
        bus.baddr_i  = 16'hFFFF;
        redirect(16'hFFFF);
        @(negedge clk);
        chk("t5_iaddr0", 32'(bus.imem_addr_o), 32'hFFFF);
        tick();
        bus.branch_i = 1'b0;
        @(negedge clk);
        chk("t5_iaddr1", 32'(bus.imem_addr_o), 32'h0000);
        tick();
        @(negedge clk);
        chk("t5_addr0", 32'(bus.addr_o), 32'hFFFF);
        tick();
        @(negedge clk);
        chk("t5_addr1", 32'(bus.addr_o), 32'h0000);
        chk("t5_inst1", bus.inst_o, 32'hA000_0000);
        tick();

        // Randomized stalls and branches.
        d0 = n_deliv;
        for (int unsigned i = 0; i < 3000; i++) begin
            bus.stall_i  = ($urandom_range(3) == 0);
            bus.branch_i = ($urandom_range(19) == 0);
            if (bus.branch_i) begin
                if ($urandom_range(3) == 0) bus.baddr_i = 16'hFFFC + 16'($urandom_range(3));
                else                        bus.baddr_i = 16'($urandom);
                redirect(bus.baddr_i);
            end
            tick();
        end
        chk("rand_progress", 32'((n_deliv - d0) > 500), 32'd1);
        bus.branch_i = 1'b0;
        bus.stall_i  = 1'b0;

        // Halt in steady state: exactly the two already-requested words drain.
        repeat (6) tick();
        bus.halt_i = 1'b1;
        d0 = n_deliv;
        for (int unsigned j = 0; j < 8; j++) begin
            @(negedge clk);
            chk("t6_req", 32'(bus.imem_req_o), 32'd0);
            tick();
            bus.halt_i = 1'b0;
        end
        @(negedge clk);
        chk("t6_v_off", 32'(bus.v_o), 32'd0);
        tick();
        chk("t6_drained", 32'(n_deliv - d0), 32'd2);

        // Reset mid-operation, then restart at RESET_PC.
        rst = 1'b0;
        #1;
        chk("t6_rst_v", 32'(bus.v_o), 32'd0);
        chk("t6_rst_req", 32'(bus.imem_req_o), 32'd0);
        repeat (2) tick();
        rst = 1'b1;
        redirect(RPC);
        @(negedge clk);
        chk("t6_restart_req", 32'(bus.imem_req_o), 32'd1);
        chk("t6_restart_iaddr", 32'(bus.imem_addr_o), 32'(RPC));
        tick();
        tick();
        @(negedge clk);
        chk("t6_restart_v", 32'(bus.v_o), 32'd1);
        chk("t6_restart_addr", 32'(bus.addr_o), 32'(RPC));
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
